// File: rtl/mem_responder_if.sv
// mem_if: request/response bundle between a CPU memory port and mem_responder.
//   master : drives req_valid/req_we/req_addr/req_wdata/req_funct3,
//            receives req_ready/rsp_valid/rsp_rdata/rsp_err
//   slave  : the opposite directions
interface mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder over a word-organised,
// little-endian RAM. Access size/sign follows the RV32 load/store funct3
// encoding; sub-word stores are read-modify-write. Every accepted request gets
// exactly one response, an error response for illegal/misaligned/out-of-range
// accesses.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset (RAM contents are kept)
//   bus          mem_if.slave request/response handshake
//   perf_loads   completed loads   (saturating, optional)
//   perf_stores  completed stores  (saturating, optional)
//   perf_errs    error responses   (saturating, optional)
//
// Build option: define MEM_PERF_CNT_EN to build the performance counters;
// otherwise the perf outputs are tied to zero.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | wait-state countdown before the array read
// RD    | read the addressed word
// MRG   | write back merged word (stores only)
// RSP   | one-cycle normal response
// ERR   | one-cycle error response, RAM untouched
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_if.slave        bus,
    output logic [15:0] perf_loads,
    output logic [15:0] perf_stores,
    output logic [15:0] perf_errs
);
    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [WCW-1:0] WCNT_INIT = (WAIT_STATES > 0) ? WCW'(WAIT_STATES - 1) : '0;

    typedef enum logic [2:0] {IDLE, WAIT, RD, MRG, RSP, ERR} state_t;

    state_t         state_q, state_d;
    logic           we_q, we_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [2:0]     f3_q, f3_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [31:0]    data_q;
    logic [31:0]    merged;
    logic [AW-1:0]  idx;
    logic           f3_ok, misaligned, out_of_range, req_bad;

    assign idx = addr_q[AW+1:2];

    // funct3[1:0]=11 never legal; funct3[2] (unsigned) only for byte/half loads.
    assign f3_ok        = (bus.req_funct3[1:0] != 2'b11) &&
                          !(bus.req_funct3[2] && (bus.req_we || bus.req_funct3[1]));
    assign misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign out_of_range = bus.req_addr[31:2] >= 30'(DEPTH_WORDS);
    assign req_bad      = !f3_ok || misaligned || out_of_range;

    function automatic logic [31:0] extract(logic [31:0] w, logic [2:0] f3, logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lane, 3'b000});
        h = 16'(w >> {lane[1], 4'b0000});
        case (f3[1:0])
            2'b00:   extract = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   extract = {{16{h[15] & ~f3[2]}}, h};
            default: extract = w;
        endcase
    endfunction

    always_comb begin
        merged = data_q;
        case (f3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        wcnt_d      = wcnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr[AW+1:0];
                    wdata_d = bus.req_wdata;
                    f3_d    = bus.req_funct3;
                    if (req_bad) begin
                        state_d     = ERR;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        wcnt_d  = WCNT_INIT;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == '0) state_d = RD;
                else              wcnt_d  = wcnt_q - 1'b1;
            end
            RD: begin
                if (we_q) begin
                    state_d = MRG;
                end else begin
                    // Load result is registered straight off the array read.
                    state_d     = RSP;
                    rsp_rdata_d = extract(mem[idx], f3_q, addr_q[1:0]);
                    rsp_err_d   = 1'b0;
                end
            end
            MRG: begin
                state_d     = RSP;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            RSP, ERR: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            wcnt_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            wcnt_q      <= wcnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Write enable comes from the registered state, so an async reset during
    // MRG forces IDLE before the next edge and the write never lands.
    always_ff @(posedge clk) begin
        if (state_q == RD)  data_q   <= mem[idx];
        if (state_q == MRG) mem[idx] <= merged;
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RSP) || (state_q == ERR);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef MEM_PERF_CNT_EN
    logic [15:0] perf_loads_q, perf_stores_q, perf_errs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_errs_q   <= '0;
        end else begin
            if (state_q == RSP && !we_q && perf_loads_q != 16'hFFFF)
                perf_loads_q <= perf_loads_q + 16'd1;
            if (state_q == RSP && we_q && perf_stores_q != 16'hFFFF)
                perf_stores_q <= perf_stores_q + 16'd1;
            if (state_q == ERR && perf_errs_q != 16'hFFFF)
                perf_errs_q <= perf_errs_q + 16'd1;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
    assign perf_errs   = perf_errs_q;
`else
    assign perf_loads  = '0;
    assign perf_stores = '0;
    assign perf_errs   = '0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    localparam int DEPTH = 1024;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] perf_loads, perf_stores, perf_errs;

    mem_if bus();

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_ld = 0, n_st = 0, n_er = 0;
    logic [7:0] mb [64];   // byte image of the low 16 words

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_perf(input int n);
`ifdef MEM_PERF_CNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    function automatic logic m_err(input logic we, input logic [31:0] a, input logic [2:0] f3);
        int  sz;
        logic legal;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        sz = 1 << f3[1:0];
        if ((a % sz) != 0) return 1'b1;
        if ((a / 4) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
        int nb, base;
        logic [31:0] v;
        nb = 1 << f3[1:0];
        base = int'(a[5:0]);
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(mb[base + i]) << (8 * i));
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        int nb, base;
        nb = 1 << f3[1:0];
        base = int'(a[5:0]);
        for (int i = 0; i < nb; i++) mb[base + i] = d[8*i +: 8];
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3,
                        output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_funct3 = f3;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_funct3 = 3'($urandom);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = i;
                break;
            end
        end
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
    endtask

    task automatic run(input string name, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        err;
        int          lat;
        xact(we, a, d, f3, rd, err, lat);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " rsp_err"}, 32'(err), 32'(exp_err));
        check({name, " rsp_rdata"}, rd, exp_rd);
        if (exp_err) n_er++;
        else if (we) n_st++;
        else n_ld++;
        if (!exp_err && we && a < 64) m_store(a, d, f3);
        @(negedge clk);
        check({name, " rsp_valid one cycle"}, 32'(bus.rsp_valid), 32'd0);
        check({name, " ready back"}, 32'(bus.req_ready), 32'd1);
        check({name, " perf_loads"}, 32'(perf_loads), 32'(exp_perf(n_ld)));
        check({name, " perf_stores"}, 32'(perf_stores), 32'(exp_perf(n_st)));
        check({name, " perf_errs"}, 32'(perf_errs), 32'(exp_perf(n_er)));
    endtask

    task automatic check_reset_state(input string name);
        check({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
        check({name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({name, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({name, " rsp_rdata"}, bus.rsp_rdata, 32'd0);
        check({name, " perf_loads"}, 32'(perf_loads), 32'd0);
        check({name, " perf_stores"}, 32'(perf_stores), 32'd0);
        check({name, " perf_errs"}, 32'(perf_errs), 32'd0);
    endtask

    initial begin
        logic        we, e;
        logic [31:0] a, d, r;
        logic [2:0]  f3;
        int          sel;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_funct3 = '0;
        for (int i = 0; i < 64; i++) mb[i] = 8'h00;

        //           we    addr          wdata          f3    rdata          err   lat
        tbl.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 3'd2, 32'h0,        1'b0, WS+3});
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd2, 32'hDEADBEEF, 1'b0, WS+2});
        tbl.push_back('{1'b1, 32'h11,   32'h000000A5, 3'd0, 32'h0,        1'b0, WS+3});
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd2, 32'hDEADA5EF, 1'b0, WS+2});
        tbl.push_back('{1'b0, 32'h11,   32'h0,        3'd0, 32'hFFFFFFA5, 1'b0, WS+2});
        tbl.push_back('{1'b0, 32'h11,   32'h0,        3'd4, 32'h000000A5, 1'b0, WS+2});
        tbl.push_back('{1'b1, 32'h12,   32'h00008001, 3'd1, 32'h0,        1'b0, WS+3});
        tbl.push_back('{1'b0, 32'h12,   32'h0,        3'd1, 32'hFFFF8001, 1'b0, WS+2});
        tbl.push_back('{1'b0, 32'h12,   32'h0,        3'd5, 32'h00008001, 1'b0, WS+2});
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd2, 32'h8001A5EF, 1'b0, WS+2});
        tbl.push_back('{1'b0, 32'h13,   32'h0,        3'd2, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b0, 32'h11,   32'h0,        3'd1, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd3, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b1, 32'h1000, 32'h11111111, 3'd2, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b1, 32'h11,   32'h22222222, 3'd1, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b1, 32'h10,   32'h33333333, 3'd4, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b0, 32'h10,   32'h0,        3'd2, 32'h8001A5EF, 1'b0, WS+2});
        tbl.push_back('{1'b1, 32'h20,   32'h0,        3'd2, 32'h0,        1'b0, WS+3});

        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            run($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3,
                tbl[i].rdata, tbl[i].err, tbl[i].lat);

        // Reset during MRG of SW 0x20: accept, WAIT, RD, then MRG.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
        bus.req_wdata = 32'h12345678; bus.req_funct3 = 3'd2;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int i = 0; i < WS + 2; i++) begin
            @(negedge clk);
            check("midop no early rsp", 32'(bus.rsp_valid), 32'd0);
        end
        rst_n = 1'b0;
        #1;
        check_reset_state("midop reset");
        n_ld = 0; n_st = 0; n_er = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midop no rsp after reset", 32'(bus.rsp_valid), 32'd0);
        end
        check_reset_state("after midop reset");
        run("midop LW 0x20", 1'b0, 32'h20, 32'h0, 3'd2, 32'h0, 1'b0, WS+2);

        for (int w = 0; w < 16; w++)
            run($sformatf("init%0d", w), 1'b1, 32'(w * 4), $urandom, 3'd2, 32'h0, 1'b0, WS+3);

        for (int i = 0; i < 250; i++) begin
            we  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h1000 + 32'($urandom_range(0, 255));
            else if (sel == 1) a = $urandom | 32'h8000_0000;
            else               a = 32'($urandom_range(0, 63));
            d = $urandom;
            e = m_err(we, a, f3);
            r = (e || we) ? 32'h0 : m_load(a, f3);
            run($sformatf("rnd%0d we=%0d a=%h f3=%0d", i, we, a, f3), we, a, d, f3, r, e,
                e ? 1 : (we ? WS + 3 : WS + 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
